// File: rtl/prbs_sync_checker.sv
// ----------------------------------------------------------------------------
// prbs_sync_checker
//
// Receive-side PRBS checker. Self-synchronises a local PRBS replica to the
// recovered serial stream, then counts checked bits and bit errors, captures
// the first 8 bits seen after lock, and falls back to hunting when the error
// count within one evaluation window reaches LOSS_THRESH.
//
// Ports:
//   clk          in   bit-rate system clock
//   reset        in   asynchronous active-low reset
//   data_in      in   recovered serial bit
//   data_valid   in   data_in is sampled on the rising edge when high
//   clr          in   synchronous clear of bit/error counters and window
//   locked       out  high while in LOCKED
//   err_pulse    out  one-cycle pulse per errored bit while LOCKED
//   bit_count    out  valid bits checked while LOCKED (saturating)
//   err_count    out  errored bits while LOCKED (saturating)
//   first_result out  first 8 bits after lock, first bit in MSB
//   first_done   out  first_result complete (sticky until reset)
// ----------------------------------------------------------------------------
module prbs_sync_checker #(
    parameter int PRBS_LEN    = 7,
    parameter int TAP         = 6,
    parameter int SYNC_LEN    = 16,
    parameter int WIN_LEN     = 64,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    input  logic             data_valid,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count,
    output logic [7:0]       first_result,
    output logic             first_done
);

    localparam int MATCH_W = $clog2(SYNC_LEN + 1);
    localparam int WIN_W   = $clog2(WIN_LEN + 1);
    localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

    localparam logic [MATCH_W-1:0] SYNC_LAST = MATCH_W'(SYNC_LEN - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WIN_LEN - 1);
    localparam logic [WERR_W:0]    THRESH    = (WERR_W + 1)'(LOSS_THRESH);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state,        state_nxt;
    logic [PRBS_LEN-1:0] s,            s_nxt;
    logic [MATCH_W-1:0]  match_cnt,    match_nxt;
    logic [WIN_W-1:0]    win_cnt,      win_nxt;
    logic [WERR_W-1:0]   win_err,      werr_nxt;
    logic [2:0]          cap_idx,      cap_nxt;
    logic [CNT_W-1:0]    bit_nxt,      errc_nxt;
    logic [7:0]          first_nxt;
    logic                first_done_nxt;
    logic                pulse_nxt;

    logic                p;
    logic                err;
    logic [WERR_W:0]     werr_sum;

    assign p        = s[PRBS_LEN-1] ^ s[TAP-1];
    assign err      = data_in ^ p;
    assign werr_sum = {1'b0, win_err} + {{WERR_W{1'b0}}, err};
    assign locked   = (state == LOCKED);

    always_comb begin
        state_nxt      = state;
        s_nxt          = s;
        match_nxt      = match_cnt;
        win_nxt        = win_cnt;
        werr_nxt       = win_err;
        cap_nxt        = cap_idx;
        bit_nxt        = bit_count;
        errc_nxt       = err_count;
        first_nxt      = first_result;
        first_done_nxt = first_done;
        pulse_nxt      = 1'b0;

        if (data_valid) begin
            case (state)
                HUNT: begin
                    // Received bits load the replica directly; an all-zero
                    // replica predicts nothing useful and never counts.
                    s_nxt = {s[PRBS_LEN-2:0], data_in};
                    if ((s != '0) && !err) begin
                        if (match_cnt == SYNC_LAST) begin
                            state_nxt = LOCKED;
                            match_nxt = '0;
                            win_nxt   = '0;
                            werr_nxt  = '0;
                            cap_nxt   = '0;
                        end else begin
                            match_nxt = match_cnt + MATCH_W'(1);
                        end
                    end else begin
                        match_nxt = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the replica runs on its own prediction.
                    s_nxt     = {s[PRBS_LEN-2:0], p};
                    pulse_nxt = err;
                    if (bit_count != '1) bit_nxt = bit_count + CNT_W'(1);
                    if (err && (err_count != '1)) errc_nxt = err_count + CNT_W'(1);
                    if (!first_done) begin
                        first_nxt = {first_result[6:0], data_in};
                        cap_nxt   = cap_idx + 3'd1;
                        if (cap_idx == 3'd7) first_done_nxt = 1'b1;
                    end
                    if (werr_sum >= THRESH) begin
                        state_nxt = HUNT;
                        match_nxt = '0;
                        win_nxt   = '0;
                        werr_nxt  = '0;
                    end else if (win_cnt == WIN_LAST) begin
                        win_nxt  = '0;
                        werr_nxt = '0;
                    end else begin
                        win_nxt  = win_cnt + WIN_W'(1);
                        werr_nxt = werr_sum[WERR_W-1:0];
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end

        // Clear overrides counting of a coincident bit; lock state and the
        // replica still advance above.
        if (clr) begin
            bit_nxt  = '0;
            errc_nxt = '0;
            win_nxt  = '0;
            werr_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= HUNT;
            s            <= '0;
            match_cnt    <= '0;
            win_cnt      <= '0;
            win_err      <= '0;
            cap_idx      <= '0;
            bit_count    <= '0;
            err_count    <= '0;
            first_result <= '0;
            first_done   <= 1'b0;
            err_pulse    <= 1'b0;
        end else begin
            state        <= state_nxt;
            s            <= s_nxt;
            match_cnt    <= match_nxt;
            win_cnt      <= win_nxt;
            win_err      <= werr_nxt;
            cap_idx      <= cap_nxt;
            bit_count    <= bit_nxt;
            err_count    <= errc_nxt;
            first_result <= first_nxt;
            first_done   <= first_done_nxt;
            err_pulse    <= pulse_nxt;
        end
    end

endmodule

// File: tb/tb_prbs_sync_checker.sv
// ----------------------------------------------------------------------------
// tb_prbs_sync_checker
//
// Drives PRBS7 streams (clean, inverted bits, all-zero) into two checker
// instances (default CNT_W and CNT_W=4) and compares every cycle against a
// bit-level reference model through an expectation queue, plus phase-end
// constants and hand-written corner sequences.
// ----------------------------------------------------------------------------
module tb_prbs_sync_checker;

    localparam int SYNC_LEN = 16;
    localparam int WIN_LEN  = 64;
    localparam int LOSS     = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_in;
    logic        data_valid;
    logic        clr;

    logic        locked, err_pulse, first_done;
    logic [31:0] bit_count, err_count;
    logic [7:0]  first_result;
    logic        locked4, err_pulse4, first_done4;
    logic [3:0]  bit_count4, err_count4;
    logic [7:0]  first_result4;

    always #5 clk = ~clk;

    prbs_sync_checker dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .clr(clr), .locked(locked), .err_pulse(err_pulse),
        .bit_count(bit_count), .err_count(err_count),
        .first_result(first_result), .first_done(first_done)
    );

    prbs_sync_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .clr(clr), .locked(locked4), .err_pulse(err_pulse4),
        .bit_count(bit_count4), .err_count(err_count4),
        .first_result(first_result4), .first_done(first_done4)
    );

    int checks   = 0;
    int failures = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [6:0]  m_s;
    bit          m_locked, m_pulse, m_fdone;
    int          m_match, m_win, m_werr, m_fidx;
    int unsigned m_bits, m_errs;
    logic [7:0]  m_first;

    function automatic void model_reset();
        m_s = '0; m_locked = 0; m_pulse = 0; m_fdone = 0;
        m_match = 0; m_win = 0; m_werr = 0; m_fidx = 0;
        m_bits = 0; m_errs = 0; m_first = '0;
    endfunction

    function automatic void model_step(bit v, bit d, bit c);
        bit p, e;
        m_pulse = 0;
        if (v) begin
            p = m_s[6] ^ m_s[5];
            e = (d != p);
            if (!m_locked) begin
                if (m_s != 0 && !e) begin
                    m_match++;
                    if (m_match == SYNC_LEN) begin
                        m_locked = 1; m_match = 0; m_win = 0; m_werr = 0; m_fidx = 0;
                    end
                end else begin
                    m_match = 0;
                end
                m_s = {m_s[5:0], d};
            end else begin
                m_s = {m_s[5:0], p};
                m_pulse = e;
                if (!c) begin
                    m_bits++;
                    if (e) m_errs++;
                end
                if (!m_fdone) begin
                    m_first = {m_first[6:0], d};
                    m_fidx++;
                    if (m_fidx == 8) m_fdone = 1;
                end
                if (m_werr + int'(e) >= LOSS) begin
                    m_locked = 0; m_match = 0; m_win = 0; m_werr = 0;
                end else if (m_win == WIN_LEN - 1) begin
                    m_win = 0; m_werr = 0;
                end else begin
                    m_win++; m_werr += int'(e);
                end
            end
        end
        if (c) begin
            m_bits = 0; m_errs = 0; m_win = 0; m_werr = 0;
        end
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          locked;
        bit          pulse;
        int unsigned bits;
        int unsigned errs;
        logic [7:0]  first;
        bit          fdone;
    } exp_t;

    exp_t sb[$];

    task automatic cycle(input bit v, input bit d, input bit c);
        exp_t e;
        data_valid = v; data_in = d; clr = c;
        model_step(v, d, c);
        e.locked = m_locked; e.pulse = m_pulse; e.bits = m_bits;
        e.errs = m_errs; e.first = m_first; e.fdone = m_fdone;
        sb.push_back(e);
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("locked",       locked,       e.locked);
            check("err_pulse",    err_pulse,    e.pulse);
            check("bit_count",    bit_count,    e.bits);
            check("err_count",    err_count,    e.errs);
            check("first_result", first_result, e.first);
            check("first_done",   first_done,   e.fdone);
            check("bit_count4",   bit_count4,   (e.bits > 15) ? 15 : e.bits);
            check("err_count4",   err_count4,   (e.errs > 15) ? 15 : e.errs);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [6:0] g;
    function automatic bit gen_bit();
        bit nb;
        nb = g[6] ^ g[5];
        g  = {g[5:0], nb};
        return nb;
    endfunction

    task automatic check_all_zero(string tag);
        check({tag, "_locked"},     locked,       0);
        check({tag, "_err_pulse"},  err_pulse,    0);
        check({tag, "_bit_count"},  bit_count,    0);
        check({tag, "_err_count"},  err_count,    0);
        check({tag, "_first"},      first_result, 0);
        check({tag, "_first_done"}, first_done,   0);
    endtask

    typedef enum int { M_RESET, M_ZERO, M_CLEAN, M_INV3, M_INV8, M_CLR } mode_t;
    typedef struct {
        string name;
        int    n;
        mode_t mode;
        bit    first_lock;
        bit    exp_locked;
        int    exp_errs;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       v;
        bit         gbits[256];
        int         lock_idx;
        bit         prev, b, inv;
        logic [7:0] ef;
        int         pulses;

        vecs[0] = '{"reset0",     2,   M_RESET, 0, 0, 0};
        vecs[1] = '{"zeros",      100, M_ZERO,  0, 0, 0};
        vecs[2] = '{"reset1",     2,   M_RESET, 0, 0, 0};
        vecs[3] = '{"clean200",   200, M_CLEAN, 1, 1, 0};
        vecs[4] = '{"inv3",       30,  M_INV3,  0, 1, 3};
        vecs[5] = '{"clr",        1,   M_CLR,   0, 1, 0};
        vecs[6] = '{"inv8",       8,   M_INV8,  0, 0, 8};
        vecs[7] = '{"relock",     23,  M_CLEAN, 0, 1, 8};
        vecs[8] = '{"clean20",    20,  M_CLEAN, 0, 1, 8};

        reset = 1'b0; data_in = 0; data_valid = 0; clr = 0;
        g = 7'h7F; lock_idx = -1;
        model_reset();

        for (int k = 0; k < 9; k++) begin
            v = vecs[k];
            pulses = 0;
            case (v.mode)
                M_RESET: begin
                    reset = 1'b0; data_valid = 0; clr = 0;
                    model_reset(); g = 7'h7F; sb.delete();
                    repeat (v.n) @(posedge clk);
                    #1;
                    check_all_zero(v.name);
                    reset = 1'b1;
                end
                M_CLR: begin
                    for (int i = 0; i < v.n; i++) cycle(0, 0, 1);
                end
                default: begin
                    for (int i = 0; i < v.n; i++) begin
                        b   = (v.mode == M_ZERO) ? 1'b0 : gen_bit();
                        inv = (v.mode == M_INV8) ||
                              (v.mode == M_INV3 && (i == 5 || i == 15 || i == 25));
                        prev = m_locked;
                        if (v.first_lock) gbits[i] = b;
                        cycle(1, b ^ inv, 0);
                        if (err_pulse) pulses++;
                        if (v.mode == M_ZERO) check("zero_match_cnt", 32'(dut.match_cnt), 0);
                        if (v.first_lock && !prev && m_locked && lock_idx < 0) lock_idx = i;
                        if (v.first_lock && i == 22) check("locked_by_bit23", locked, 1);
                    end
                end
            endcase
            if (v.mode != M_RESET) begin
                check({v.name, "_end_locked"}, locked,    v.exp_locked);
                check({v.name, "_end_errs"},   err_count, v.exp_errs);
            end
            if (v.mode == M_INV3) check("inv3_pulses", pulses, 3);
            if (v.first_lock) begin
                check("first_done_set", first_done, 1);
                check("sat_bit_count4", bit_count4, 4'hF);
                check("lock_seen", (lock_idx >= 0), 1);
                ef = '0;
                if (lock_idx >= 0)
                    for (int j = 1; j <= 8; j++) ef = {ef[6:0], gbits[lock_idx + j]};
                check("first_vs_stream", first_result, ef);
                check("bits_after_lock", bit_count, 199 - lock_idx);
            end
        end

        // clr together with a valid bit: counters zero, then resume at 1
        cycle(1, gen_bit(), 1);
        check("clrv_bit_count", bit_count, 0);
        check("clrv_err_count", err_count, 0);
        check("clrv_locked",    locked,    1);
        cycle(1, gen_bit(), 0);
        check("resume_bit_count", bit_count, 1);

        // asynchronous reset between clock edges
        data_valid = 1; data_in = gen_bit();
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset(); sb.delete();
        @(posedge clk); #1;
        check("async_rst_held_locked", locked, 0);
        data_valid = 0;
        reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
